// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated arbiter that packs user words into BFT leaf packets.
// Define LEAF_ARB_SEQ_NUM_EN to add per-port 7-bit sequence numbers in bits [38:32].
`timescale 1ns/1ps

module leaf_out_arbiter #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_OUT_PORTS         = 4,
  parameter int unsigned CREDIT_INIT           = 128,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   resend,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]  din_leaf_user2arb,
  input  logic [NUM_OUT_PORTS-1:0]               vld_user2arb,
  output logic [NUM_OUT_PORTS-1:0]               ack_arb2user,
  input  logic                                   cfg_vld,
  input  logic [2:0]                             cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]               cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]               cfg_dport,
  input  logic                                   credit_upd_vld,
  input  logic [2:0]                             credit_upd_port,
  output logic [PACKET_BITS-1:0]                 dout_leaf_arb2bft
);

  localparam int unsigned SeqBits = 7;

  typedef enum logic [1:0] {StInit, StRun, StStall} state_e;

  state_e                   state_q;
  logic [7:0]               credit_q [NUM_OUT_PORTS];
  logic [7:0]               credit_d [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] configured_q;
  logic [2:0]               last_grant_q;
  logic [PACKET_BITS-1:0]   dout_q;
  logic [SeqBits-1:0]       seq_val  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] upd_hit;
  logic [NUM_OUT_PORTS-1:0] cfg_hit;
  logic                     grant_vld;
  logic [2:0]               grant_idx;
  logic [PACKET_BITS-1:0]   packet;

  // Only RUN with resend low may grant; reset gates the combinational ack too.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2arb[i] && (credit_q[i] != 8'd0) && configured_q[i];
      upd_hit[i]  = credit_upd_vld && (credit_upd_port == 3'(i));
      cfg_hit[i]  = cfg_vld && (cfg_port == 3'(i));
    end
    if (reset || (state_q != StRun) || resend) begin
      eligible = '0;
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = (32'(last_grant_q) + 32'd1 + k) % NUM_OUT_PORTS;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (!grant_vld && (idx == 32'(i)) && eligible[i]) begin
          grant_vld = 1'b1;
          grant_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      ack_arb2user[i] = grant_vld && (grant_idx == 3'(i));
    end
  end

  always_comb begin
    logic [PAYLOAD_BITS-1:0]  sel_payload;
    logic [NUM_LEAF_BITS-1:0] sel_leaf;
    logic [NUM_PORT_BITS-1:0] sel_dport;
    logic [SeqBits-1:0]       sel_seq;
    sel_payload = '0;
    sel_leaf    = '0;
    sel_dport   = '0;
    sel_seq     = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (ack_arb2user[i]) begin
        sel_payload = din_leaf_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_leaf    = leaf_q[i];
        sel_dport   = dport_q[i];
        sel_seq     = seq_val[i];
      end
    end
    packet = {1'b1, sel_leaf, sel_dport, sel_seq, sel_payload};
  end

  // Credit math in 9 bits so update-plus-grant saturates instead of wrapping.
  always_comb begin
    logic [8:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit_q[i]}
            + (upd_hit[i] ? 9'(FREESPACE_UPDATE_SIZE) : 9'd0)
            - {8'd0, ack_arb2user[i]};
      credit_d[i] = (sum > 9'd255) ? 8'hFF : sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      dout_q       <= '0;
      last_grant_q <= 3'(NUM_OUT_PORTS - 1);
      configured_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= 8'(CREDIT_INIT);
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
      end
    end else begin
      unique case (state_q)
        StInit: begin
          state_q      <= resend ? StStall : StRun;
          configured_q <= '0;
          for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= 8'(CREDIT_INIT);
            leaf_q[i]   <= '0;
            dport_q[i]  <= '0;
          end
        end
        StRun, StStall: begin
          state_q <= resend ? StStall : StRun;
          for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
            if (cfg_hit[i]) begin
              leaf_q[i]       <= cfg_leaf;
              dport_q[i]      <= cfg_dport;
              configured_q[i] <= 1'b1;
            end
          end
        end
        default: state_q <= StInit;
      endcase
      dout_q <= grant_vld ? packet : '0;
      if (grant_vld) begin
        last_grant_q <= grant_idx;
      end
    end
  end

`ifdef LEAF_ARB_SEQ_NUM_EN
  logic [SeqBits-1:0] seq_q [NUM_OUT_PORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        seq_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (ack_arb2user[i]) begin
          seq_q[i] <= seq_q[i] + 7'd1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      seq_val[i] = seq_q[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      seq_val[i] = '0;
    end
  end
`endif

  assign dout_leaf_arb2bft = dout_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: vector table for round-robin/stall, plus
// credit exhaustion, saturation, reset, and same-cycle config sequences.
`timescale 1ns/1ps

module tb_leaf_out_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         resend;
  logic [127:0] din;
  logic [3:0]   vld;
  logic [3:0]   ack;
  logic         cfg_vld;
  logic [2:0]   cfg_port;
  logic [4:0]   cfg_leaf;
  logic [3:0]   cfg_dport;
  logic         upd_vld;
  logic [2:0]   upd_port;
  logic [48:0]  dout;

  int n_tests = 0;
  int n_fail  = 0;
  int seq_cnt [4];
  logic [4:0] leaf_m  [4];
  logic [3:0] dport_m [4];

  typedef struct {
    logic [3:0] vld;
    logic       resend;
    logic [3:0] ack;
    int         dsrc;   // port whose packet is expected on dout, -1 for zero
  } vec_t;

  vec_t tbl [15];

  leaf_out_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .resend            (resend),
    .din_leaf_user2arb (din),
    .vld_user2arb      (vld),
    .ack_arb2user      (ack),
    .cfg_vld           (cfg_vld),
    .cfg_port          (cfg_port),
    .cfg_leaf          (cfg_leaf),
    .cfg_dport         (cfg_dport),
    .credit_upd_vld    (upd_vld),
    .credit_upd_port   (upd_port),
    .dout_leaf_arb2bft (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] payload(input int p);
    return 32'hA000_0001 + 32'(p) * 32'h0011_0011;
  endfunction

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] d, input int n,
                                     input logic [31:0] pl);
    logic [6:0] s;
`ifdef LEAF_ARB_SEQ_NUM_EN
    s = 7'(n % 128);
`else
    s = 7'd0;
`endif
    return {1'b1, l, d, s, pl};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int p = 0; p < 4; p++) begin
      seq_cnt[p] = 0;
      leaf_m[p]  = '0;
      dport_m[p] = '0;
    end
  endtask

  task automatic cfg_write(input logic [2:0] p, input logic [4:0] l, input logic [3:0] d);
    cfg_vld = 1'b1; cfg_port = p; cfg_leaf = l; cfg_dport = d;
    next_cycle();
    cfg_vld = 1'b0;
    if (p < 3'd4) begin
      leaf_m[p]  = l;
      dport_m[p] = d;
    end
  endtask

  // Holds current vld, optionally pulses credit updates, counts acks until idle.
  task automatic run_count(input int budget, input int upd_at, input logic [2:0] port,
                           input int pulses, output int acks, output int bad);
    int prev;
    int idle;
    logic [48:0] e;
    acks = 0; bad = 0; prev = -1; idle = 0;
    for (int i = 0; i < budget; i++) begin
      upd_vld  = (upd_at >= 0) && (i >= upd_at) && (i < upd_at + pulses);
      upd_port = port;
      #1;
      if (prev < 0) e = '0;
      else begin
        e = mk(leaf_m[prev], dport_m[prev], seq_cnt[prev], payload(prev));
        seq_cnt[prev]++;
      end
      if (dout !== e) bad++;
      if ($countones(ack) > 1) bad++;
      prev = -1;
      for (int p = 0; p < 4; p++) if (ack[p]) prev = p;
      if (ack != 4'd0) begin
        acks++;
        idle = 0;
      end else idle++;
      next_cycle();
      if (idle >= 8 && i >= upd_at + pulses) begin
        upd_vld = 1'b0;
        return;
      end
    end
    upd_vld = 1'b0;
    bad++;
  endtask

  initial begin
    int acks;
    int bad;
    logic [48:0] e;

    tbl[0]  = '{4'hF, 1'b0, 4'h1, -1};
    tbl[1]  = '{4'hF, 1'b0, 4'h2,  0};
    tbl[2]  = '{4'hF, 1'b0, 4'h4,  1};
    tbl[3]  = '{4'hF, 1'b0, 4'h8,  2};
    tbl[4]  = '{4'hF, 1'b0, 4'h1,  3};
    tbl[5]  = '{4'hA, 1'b0, 4'h2,  0};
    tbl[6]  = '{4'hA, 1'b0, 4'h8,  1};
    tbl[7]  = '{4'hA, 1'b0, 4'h2,  3};
    tbl[8]  = '{4'h0, 1'b0, 4'h0,  1};
    tbl[9]  = '{4'h4, 1'b0, 4'h4, -1};
    tbl[10] = '{4'hF, 1'b1, 4'h0,  2};
    tbl[11] = '{4'hF, 1'b1, 4'h0, -1};
    tbl[12] = '{4'hF, 1'b0, 4'h0, -1};
    tbl[13] = '{4'hF, 1'b0, 4'h8, -1};
    tbl[14] = '{4'hF, 1'b0, 4'h1,  3};

    for (int p = 0; p < 4; p++) din[p*32 +: 32] = payload(p);
    reset = 1'b1; resend = 1'b0; vld = 4'h0; cfg_vld = 1'b0; cfg_port = '0;
    cfg_leaf = '0; cfg_dport = '0; upd_vld = 1'b0; upd_port = '0;
    clear_model();

    next_cycle();
    vld = 4'hF;
    #1;
    check("reset_ack", 64'(ack), 64'h0);
    check("reset_dout", 64'(dout), 64'h0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("init_ack", 64'(ack), 64'h0);
    next_cycle();
    vld = 4'h0;
    for (int p = 0; p < 4; p++) cfg_write(3'(p), 5'(p + 1), 4'(p + 4));

    for (int v = 0; v < 15; v++) begin
      vld = tbl[v].vld;
      resend = tbl[v].resend;
      #1;
      check($sformatf("vec%0d_ack", v), 64'(ack), 64'(tbl[v].ack));
      if (tbl[v].dsrc < 0) e = '0;
      else begin
        e = mk(leaf_m[tbl[v].dsrc], dport_m[tbl[v].dsrc], seq_cnt[tbl[v].dsrc],
               payload(tbl[v].dsrc));
        seq_cnt[tbl[v].dsrc]++;
      end
      check($sformatf("vec%0d_dout", v), 64'(dout), 64'(e));
      next_cycle();
    end

    // Reset mid-stream: in-flight packet still visible, then dropped.
    reset = 1'b1;
    #1;
    check("midrst_ack", 64'(ack), 64'h0);
    check("midrst_dout0", 64'(dout), 64'(mk(leaf_m[0], dport_m[0], seq_cnt[0], payload(0))));
    next_cycle();
    check("midrst_dout1", 64'(dout), 64'h0);
    clear_model();
    next_cycle();
    reset = 1'b0;
    #1;
    check("init2_ack", 64'(ack), 64'h0);
    next_cycle();
    check("unconfigured_ack", 64'(ack), 64'h0);

    vld = 4'h4;
    cfg_write(3'd6, 5'd1, 4'd1);
    #1;
    check("cfg_oob_ack", 64'(ack), 64'h0);
    next_cycle();

    vld = 4'h0;
    cfg_write(3'd2, 5'd9, 4'd2);
    vld = 4'h4;
    run_count(300, -1, 3'd2, 0, acks, bad);
    check("exhaust_count", 64'(acks), 64'd128);
    check("exhaust_pkts", 64'(bad), 64'd0);
    run_count(50, 0, 3'd6, 1, acks, bad);
    check("upd_oob_count", 64'(acks), 64'd0);
    run_count(200, 0, 3'd2, 1, acks, bad);
    check("upd_count", 64'(acks), 64'd64);
    check("upd_pkts", 64'(bad), 64'd0);

    vld = 4'h0;
    run_count(30, 0, 3'd2, 4, acks, bad);
    check("sat_fill_count", 64'(acks), 64'd0);
    vld = 4'h4;
    run_count(400, 5, 3'd2, 1, acks, bad);
    check("sat_count", 64'(acks), 64'd261);
    check("sat_pkts", 64'(bad), 64'd0);

    vld = 4'h0;
    cfg_write(3'd1, 5'd2, 4'd5);
    vld = 4'h2;
    cfg_vld = 1'b1; cfg_port = 3'd1; cfg_leaf = 5'd7; cfg_dport = 4'd3;
    #1;
    check("cfgrace_ack0", 64'(ack), 64'h2);
    check("cfgrace_dout0", 64'(dout), 64'h0);
    next_cycle();
    cfg_vld = 1'b0;
    #1;
    check("cfgrace_ack1", 64'(ack), 64'h2);
    check("cfgrace_old", 64'(dout), 64'(mk(5'd2, 4'd5, seq_cnt[1], payload(1))));
    seq_cnt[1]++;
    next_cycle();
    vld = 4'h0;
    #1;
    check("cfgrace_new", 64'(dout), 64'(mk(5'd7, 4'd3, seq_cnt[1], payload(1))));
    next_cycle();
    #1;
    check("idle_dout", 64'(dout), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
